// File: rtl/frame_stats.sv
// frame_stats: per-frame RGB sums, min/max, row-length error flag and frame counter
//   clk, rst (async, active-low)
//   s_axis_tvalid/tuser(SOF)/tlast(EOL)/tdata{R,G,B}  video input, no backpressure
//   stats_valid   one-cycle pulse when a frame completes
//   sum_r/g/b     channel sums of the last completed frame
//   min_rgb/max_rgb  per-channel min/max, packed like tdata
//   stats_err     last completed frame had a row-length error
//   frame_abort   one-cycle pulse when an early SOF abandons a frame
//   frame_cnt     completed frames since reset (wraps)
module frame_stats #(
   parameter int Nrows = 512,
   parameter int Ncol  = 512,
   parameter int SUM_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_axis_tvalid,
   input  logic             s_axis_tuser,
   input  logic             s_axis_tlast,
   input  logic [23:0]      s_axis_tdata,
   output logic             stats_valid,
   output logic [SUM_W-1:0] sum_r,
   output logic [SUM_W-1:0] sum_g,
   output logic [SUM_W-1:0] sum_b,
   output logic [23:0]      min_rgb,
   output logic [23:0]      max_rgb,
   output logic             stats_err,
   output logic             frame_abort,
   output logic [15:0]      frame_cnt
);
   localparam int CW = $clog2(Ncol + 1);
   localparam int RW = $clog2(Nrows + 1);
   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t state, state_n;
   logic [CW-1:0] col, col_n, col_cur;
   logic [RW-1:0] row, row_n, row_cur;
   logic err_acc, err_n, err_cur;
   logic [SUM_W-1:0] acc_r, acc_g, acc_b, acc_r_n, acc_g_n, acc_b_n;
   logic [23:0] mn, mx, mn_n, mx_n;
   logic sof, beat, done;

   // An SOF beat (in either state) restarts the frame, so the "current" counters
   // it sees are zero; EOL rules then apply uniformly to SOF and normal beats.
   always_comb begin
      sof     = s_axis_tvalid & s_axis_tuser;
      beat    = sof | (s_axis_tvalid & (state == ACTIVE));
      row_cur = sof ? '0 : row;
      col_cur = sof ? '0 : col;
      err_cur = sof ? 1'b0 : err_acc;
      col_n   = s_axis_tlast ? '0 : sof ? CW'(1) : (int'(col) >= Ncol - 1) ? CW'(Ncol) : col + 1'b1;
      row_n   = s_axis_tlast ? row_cur + 1'b1 : row_cur;
      // Without EOL, reaching Ncol beats in a row means the EOL was missed.
      err_n   = s_axis_tlast ? (err_cur | (int'(col_cur) + 1 != Ncol))
                             : (!sof & (err_acc | (int'(col) + 1 >= Ncol)));
      done    = beat & s_axis_tlast & (int'(row_cur) == Nrows - 1);
      acc_r_n = (sof ? '0 : acc_r) + SUM_W'(s_axis_tdata[23:16]);
      acc_g_n = (sof ? '0 : acc_g) + SUM_W'(s_axis_tdata[15:8]);
      acc_b_n = (sof ? '0 : acc_b) + SUM_W'(s_axis_tdata[7:0]);
      mn_n    = mn;
      mx_n    = mx;
      for (int i = 0; i < 3; i++) begin
         mn_n[8*i +: 8] = (sof || s_axis_tdata[8*i +: 8] < mn[8*i +: 8]) ? s_axis_tdata[8*i +: 8] : mn[8*i +: 8];
         mx_n[8*i +: 8] = (sof || s_axis_tdata[8*i +: 8] > mx[8*i +: 8]) ? s_axis_tdata[8*i +: 8] : mx[8*i +: 8];
      end
      state_n = done ? IDLE : sof ? ACTIVE : state;
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else      state <= state_n;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col         <= '0;
         row         <= '0;
         err_acc     <= 1'b0;
         acc_r       <= '0;
         acc_g       <= '0;
         acc_b       <= '0;
         mn          <= '0;
         mx          <= '0;
         stats_valid <= 1'b0;
         frame_abort <= 1'b0;
         sum_r       <= '0;
         sum_g       <= '0;
         sum_b       <= '0;
         min_rgb     <= '0;
         max_rgb     <= '0;
         stats_err   <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         stats_valid <= done;
         frame_abort <= sof & (state == ACTIVE);
         if (beat) begin
            col     <= col_n;
            row     <= row_n;
            err_acc <= err_n;
            acc_r   <= acc_r_n;
            acc_g   <= acc_g_n;
            acc_b   <= acc_b_n;
            mn      <= mn_n;
            mx      <= mx_n;
         end
         if (done) begin
            sum_r     <= acc_r_n;
            sum_g     <= acc_g_n;
            sum_b     <= acc_b_n;
            min_rgb   <= mn_n;
            max_rgb   <= mx_n;
            stats_err <= err_n;
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end
endmodule

// File: doc/frame_stats.md
Name: frame_stats

Overview:
- Per-frame statistics sink placed directly downstream of color_correction.
- Consumes its master AXI-Stream video output: 24-bit RGB, tuser = SOF, tlast = EOL, no tready.
- For each complete frame, produces per-channel pixel sums, per-channel min/max, a geometry error flag and a frame counter.
- Feeds the white-balance/gain control software and the verification bench.

Parameters:
- Nrows, 512: active rows per frame.
- Ncol, 512: active pixels per row.
- SUM_W, 32: width of each channel sum accumulator. Constraint: Nrows*Ncol*255 < 2^SUM_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- s_axis_tvalid  in  1  pixel beat valid; a beat is accepted on every clk edge where this is 1.
- s_axis_tuser  in  1  SOF, set on the first beat of a frame.
- s_axis_tlast  in  1  EOL, set on the last beat of a row.
- s_axis_tdata  in  24  R[23:16], G[15:8], B[7:0].
- stats_valid  out  1  one-cycle pulse when a frame completes.
- sum_r, sum_g, sum_b  out  SUM_W  channel sums of the last completed frame.
- min_rgb  out  24  per-channel minimum, packed like tdata.
- max_rgb  out  24  per-channel maximum, packed like tdata.
- stats_err  out  1  last completed frame had a row-length error.
- frame_abort  out  1  one-cycle pulse when a frame in progress is abandoned by an early SOF.
- frame_cnt  out  16  completed frames since reset; wraps 0xFFFF -> 0.

Behaviour:
- Reset (rst=0), asynchronous:
  - Outputs: all zero (stats_valid, frame_abort, sums, min_rgb, max_rgb, stats_err, frame_cnt).
  - Internal: state=IDLE; col, row and accumulators cleared.
  - Reset mid-frame discards that frame; nothing is reported for it.
- States: IDLE, ACTIVE.
- IDLE:
  - Accepted beats with tuser=0 are ignored.
  - Accepted beat with tuser=1 -> ACTIVE. Accumulators load from that pixel: sum=pixel, min=max=pixel, col=1, row=0, err_acc=0.
  - If that beat also has tlast=1, apply the EOL rules below to it.
- ACTIVE, accepted beat with tuser=0:
  - sum_x += x; min_x = min(min_x, x); max_x = max(max_x, x), per channel.
  - tlast=0: col++. If col reaches Ncol (missing EOL): err_acc=1 and col saturates at Ncol.
  - tlast=1: err_acc |= (col+1 != Ncol); col=0; row++.
- Frame completion: a tlast beat when row==Nrows-1. On that same edge:
  - Outputs load with the final pixel included; stats_err=err_acc.
  - frame_cnt++.
  - stats_valid=1 for exactly the following cycle; state -> IDLE.
  - Latency: outputs valid one cycle after the last beat is sampled.
- Early SOF (tuser=1 in ACTIVE): the in-progress frame is discarded. frame_abort pulses one cycle; stats outputs are unchanged. Accumulators reload from this pixel as in IDLE; state stays ACTIVE.
- Back-to-back frames: an SOF on the cycle right after completion is accepted normally. stats_valid and the new SOF beat may coincide.
- tvalid=0 cycles: no state change; gaps of any length are legal.
- Outputs hold their values until the next completion or reset.
- Sums never wrap under the SUM_W constraint. Min/max compare unsigned 8-bit values.

Test Plan:
- Nrows=Ncol=4; constant pixel 0x804020 for 16 beats, SOF on first, tlast every 4th -> stats_valid once; sum_r=2048, sum_g=1024, sum_b=512; min_rgb=max_rgb=0x804020; stats_err=0; frame_cnt=1.
- Pixel k = {k,k,k} for k=0..15 with random tvalid gaps -> sum_r=sum_g=sum_b=120; min_rgb=0x000000; max_rgb=0x0F0F0F; stats_err=0.
- Row 1 given tlast after 3 beats (15 beats total, 4 tlasts) -> stats_valid once; stats_err=1; frame_cnt increments.
- SOF re-issued on beat 7, then a clean 16-beat constant 0x101010 frame -> frame_abort pulses once; one stats_valid with sum_r=256 and stats_err=0.
- 10 beats with tuser=0 in IDLE -> no stats_valid, outputs stay 0. Then a valid frame immediately followed by a second SOF -> frame_cnt 1 then 2; stats_valid pulses twice.
- rst=0 asserted mid-frame between clock edges -> outputs 0 immediately. After release, a clean frame reports correct sums with frame_cnt=1.
